// File: rtl/adpll_acq_ctrl_if.sv
// Control/status bundle between the ADPLL acquisition sequencer and its
// host: acquisition commands, the decimated phase-error stream, sweep
// configuration and the loop-facing outputs.
interface adpll_acq_ctrl_if #(
    parameter int PW = 32,
    parameter int EW = 12
);
    logic                 start;
    logic                 stop;
    logic                 err_vld;
    logic signed [EW-1:0] err;
    logic signed [PW-1:0] f_start;
    logic signed [PW-1:0] f_stop;
    logic signed [PW-1:0] f_step;
    logic        [EW-2:0] lock_thr;
    logic signed [PW-1:0] base_freq;
    logic                 pi_rst;
    logic                 locked;
    logic                 sweep_fail;
    logic        [2:0]    state;

    modport master (
        output start, stop, err_vld, err, f_start, f_stop, f_step, lock_thr,
        input  base_freq, pi_rst, locked, sweep_fail, state
    );

    modport slave (
        input  start, stop, err_vld, err, f_start, f_stop, f_step, lock_thr,
        output base_freq, pi_rst, locked, sweep_fail, state
    );
endinterface

// File: rtl/adpll_acq_ctrl.sv
// Acquisition and lock sequencer for the ADPLL loop. Steps base_freq across
// a latched range until the phase error stays inside a threshold, tracks
// loss of lock and re-acquires from f_start, or reports range exhaustion.
module adpll_acq_ctrl #(
    parameter int PW         = 32,
    parameter int EW         = 12,
    parameter int DWELL      = 256,
    parameter int LOCK_CNT   = 64,
    parameter int UNLOCK_CNT = 16
) (
    input logic             clk,
    input logic             rst,
    adpll_acq_ctrl_if.slave bus
);
    localparam int DW = $clog2(DWELL + 1);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SWEEP  = 3'd2,
        TRACK  = 3'd3,
        FAIL   = 3'd4
    } state_t;

    state_t               state_q;
    logic signed [PW-1:0] base_q;
    logic                 pi_rst_q;
    logic                 locked_q;
    logic                 fail_q;
    logic signed [PW-1:0] f_stop_q;
    logic signed [PW-1:0] f_step_q;
    logic        [EW-2:0] lock_thr_q;
    logic        [DW-1:0] dwell_q;
    logic        [GW-1:0] good_q;
    logic        [BW-1:0] bad_q;

    logic        [EW:0]   mag;
    logic                 good;
    logic        [DW-1:0] dwell_nxt;
    logic        [GW-1:0] good_nxt;
    logic        [BW-1:0] bad_nxt;
    logic signed [PW:0]   sum;
    logic signed [PW:0]   stop_ext;
    logic                 over;

    assign bus.state      = state_q;
    assign bus.base_freq  = base_q;
    assign bus.pi_rst     = pi_rst_q;
    assign bus.locked     = locked_q;
    assign bus.sweep_fail = fail_q;

    // Sample classification, counter increments and the widened sweep step.
    always_comb begin
        mag = '0;
        if (bus.err[EW-1]) begin
            mag = -{bus.err[EW-1], bus.err};
        end else begin
            mag = {1'b0, bus.err};
        end
        good      = (mag <= {2'b00, lock_thr_q});
        dwell_nxt = dwell_q + DW'(1);
        good_nxt  = good ? good_q + GW'(1) : '0;
        bad_nxt   = good ? '0 : bad_q + BW'(1);
        sum       = {base_q[PW-1], base_q} + {f_step_q[PW-1], f_step_q};
        stop_ext  = {f_stop_q[PW-1], f_stop_q};
        over      = (sum > stop_ext);
    end

    // Sequencer: state, registered outputs, counters and latched config.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            pi_rst_q   <= 1'b1;
            locked_q   <= 1'b0;
            fail_q     <= 1'b0;
            f_stop_q   <= '0;
            f_step_q   <= '0;
            lock_thr_q <= '0;
            dwell_q    <= '0;
            good_q     <= '0;
            bad_q      <= '0;
        end else if (bus.stop) begin
            state_q  <= IDLE;
            pi_rst_q <= 1'b1;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
            dwell_q  <= '0;
            good_q   <= '0;
            bad_q    <= '0;
        end else begin
            case (state_q)
                IDLE, FAIL: begin
                    if (bus.start) begin
                        state_q    <= SETTLE;
                        base_q     <= bus.f_start;
                        pi_rst_q   <= 1'b0;
                        fail_q     <= 1'b0;
                        f_stop_q   <= bus.f_stop;
                        f_step_q   <= bus.f_step;
                        lock_thr_q <= bus.lock_thr;
                        dwell_q    <= '0;
                        good_q     <= '0;
                        bad_q      <= '0;
                    end
                end
                SETTLE: begin
                    // pi_rst may arrive high from a re-acquire; drop it after one cycle
                    pi_rst_q <= 1'b0;
                    if (bus.err_vld) begin
                        dwell_q <= dwell_nxt;
                        good_q  <= good_nxt;
                        if (good_nxt == GW'(LOCK_CNT)) begin
                            state_q  <= TRACK;
                            locked_q <= 1'b1;
                            bad_q    <= '0;
                        end else if (dwell_nxt == DW'(DWELL)) begin
                            state_q  <= SWEEP;
                            pi_rst_q <= 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    if (over) begin
                        state_q <= FAIL;
                        fail_q  <= 1'b1;
                    end else begin
                        state_q  <= SETTLE;
                        base_q   <= sum[PW-1:0];
                        pi_rst_q <= 1'b0;
                        dwell_q  <= '0;
                        good_q   <= '0;
                    end
                end
                TRACK: begin
                    if (bus.err_vld) begin
                        bad_q <= bad_nxt;
                        if (bad_nxt == BW'(UNLOCK_CNT)) begin
                            state_q  <= SETTLE;
                            base_q   <= bus.f_start;
                            pi_rst_q <= 1'b1;
                            locked_q <= 1'b0;
                            dwell_q  <= '0;
                            good_q   <= '0;
                            bad_q    <= '0;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    pi_rst_q <= 1'b1;
                    locked_q <= 1'b0;
                    fail_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adpll_acq_ctrl.sv
// Directed bench for adpll_acq_ctrl with a small expectation scoreboard.
module tb_adpll_acq_ctrl;
    localparam int PW = 32;
    localparam int EW = 12;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_SWEEP  = 3'd2;
    localparam logic [2:0] S_TRACK  = 3'd3;
    localparam logic [2:0] S_FAIL   = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    adpll_acq_ctrl_if #(.PW(PW), .EW(EW)) bus ();

    adpll_acq_ctrl #(
        .PW(PW), .EW(EW), .DWELL(8), .LOCK_CNT(4), .UNLOCK_CNT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string          tag;
        logic [2:0]     st;
        logic [PW-1:0]  bf;
        logic           pr;
        logic           lk;
        logic           sf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic expect_out(input string tag, input logic [2:0] st,
                              input logic [PW-1:0] bf, input logic pr,
                              input logic lk, input logic sf);
        exp_t e;
        e.tag = tag; e.st = st; e.bf = bf; e.pr = pr; e.lk = lk; e.sf = sf;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_sb();
        exp_t e;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_cmp++;
            assert (bus.state === e.st) else begin
                n_bad++;
                $error("FAIL %s.state got=%0d exp=%0d", e.tag, bus.state, e.st);
            end
            n_cmp++;
            assert (bus.base_freq === e.bf) else begin
                n_bad++;
                $error("FAIL %s.base_freq got=%0d exp=%0d", e.tag, bus.base_freq, $signed(e.bf));
            end
            n_cmp++;
            assert (bus.pi_rst === e.pr) else begin
                n_bad++;
                $error("FAIL %s.pi_rst got=%0b exp=%0b", e.tag, bus.pi_rst, e.pr);
            end
            n_cmp++;
            assert (bus.locked === e.lk) else begin
                n_bad++;
                $error("FAIL %s.locked got=%0b exp=%0b", e.tag, bus.locked, e.lk);
            end
            n_cmp++;
            assert (bus.sweep_fail === e.sf) else begin
                n_bad++;
                $error("FAIL %s.sweep_fail got=%0b exp=%0b", e.tag, bus.sweep_fail, e.sf);
            end
        end
    endtask

    task automatic sample(input int e);
        bus.err     = EW'(e);
        bus.err_vld = 1'b1;
        tick();
        bus.err_vld = 1'b0;
    endtask

    task automatic samp_chk(input int e, input string tag, input logic [2:0] st,
                            input logic [PW-1:0] bf, input logic pr,
                            input logic lk, input logic sf);
        expect_out(tag, st, bf, pr, lk, sf);
        sample(e);
        check_sb();
    endtask

    task automatic idle_chk(input string tag, input logic [2:0] st,
                            input logic [PW-1:0] bf, input logic pr,
                            input logic lk, input logic sf);
        expect_out(tag, st, bf, pr, lk, sf);
        tick();
        check_sb();
    endtask

    task automatic start_chk(input string tag, input logic [PW-1:0] bf);
        bus.start = 1'b1;
        expect_out(tag, S_SETTLE, bf, 1'b0, 1'b0, 1'b0);
        tick();
        bus.start = 1'b0;
        check_sb();
    endtask

    task automatic stop_chk(input string tag, input logic [PW-1:0] bf);
        bus.stop = 1'b1;
        expect_out(tag, S_IDLE, bf, 1'b1, 1'b0, 1'b0);
        tick();
        bus.stop = 1'b0;
        check_sb();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.err_vld  = 1'b0;
        bus.err      = '0;
        bus.f_start  = 1000;
        bus.f_stop   = 2000;
        bus.f_step   = 50;
        bus.lock_thr = 10;

        // Reset
        rst = 1'b1;
        expect_out("reset", S_IDLE, 0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        check_sb();
        rst = 1'b0;
        idle_chk("idle_hold", S_IDLE, 0, 1'b1, 1'b0, 1'b0);

        // Immediate lock
        start_chk("start1", 1000);
        samp_chk(5, "lk1", S_SETTLE, 1000, 1'b0, 1'b0, 1'b0);
        samp_chk(5, "lk2", S_SETTLE, 1000, 1'b0, 1'b0, 1'b0);
        samp_chk(5, "lk3", S_SETTLE, 1000, 1'b0, 1'b0, 1'b0);
        samp_chk(5, "lk4", S_TRACK, 1000, 1'b0, 1'b1, 1'b0);
        bus.f_start = 3000;
        bus.start   = 1'b1;
        expect_out("start_in_track", S_TRACK, 1000, 1'b0, 1'b1, 1'b0);
        tick();
        bus.start   = 1'b0;
        bus.f_start = 1000;
        check_sb();
        stop_chk("stop1", 1000);

        // Step: good-good-bad-good never reaches lock, dwell expires into SWEEP
        start_chk("start2", 1000);
        samp_chk(5,   "ggbg_g1", S_SETTLE, 1000, 1'b0, 1'b0, 1'b0);
        samp_chk(5,   "ggbg_g2", S_SETTLE, 1000, 1'b0, 1'b0, 1'b0);
        samp_chk(100, "ggbg_b",  S_SETTLE, 1000, 1'b0, 1'b0, 1'b0);
        samp_chk(5,   "ggbg_g3", S_SETTLE, 1000, 1'b0, 1'b0, 1'b0);
        sample(100);
        sample(100);
        sample(100);
        samp_chk(100, "dwell_end", S_SWEEP, 1000, 1'b1, 1'b0, 1'b0);
        samp_chk(5,   "sweep_ign", S_SETTLE, 1050, 1'b0, 1'b0, 1'b0);
        samp_chk(5,   "s2_g1",     S_SETTLE, 1050, 1'b0, 1'b0, 1'b0);
        samp_chk(5,   "s2_g2",     S_SETTLE, 1050, 1'b0, 1'b0, 1'b0);
        samp_chk(5,   "s2_g3",     S_SETTLE, 1050, 1'b0, 1'b0, 1'b0);
        samp_chk(5,   "s2_lock",   S_TRACK,  1050, 1'b0, 1'b1, 1'b0);

        // Loss of lock; a good sample in between clears the bad count
        samp_chk(-2048, "lol_b1",   S_TRACK,  1050, 1'b0, 1'b1, 1'b0);
        samp_chk(3,     "lol_g",    S_TRACK,  1050, 1'b0, 1'b1, 1'b0);
        samp_chk(-2048, "lol_b2",   S_TRACK,  1050, 1'b0, 1'b1, 1'b0);
        samp_chk(-2048, "lol_loss", S_SETTLE, 1000, 1'b1, 1'b0, 1'b0);
        idle_chk("lol_settle", S_SETTLE, 1000, 1'b0, 1'b0, 1'b0);

        // Threshold boundary: |err| == lock_thr is good, lock_thr+1 is bad
        samp_chk(-10, "thr_g1",   S_SETTLE, 1000, 1'b0, 1'b0, 1'b0);
        samp_chk(10,  "thr_g2",   S_SETTLE, 1000, 1'b0, 1'b0, 1'b0);
        samp_chk(-10, "thr_g3",   S_SETTLE, 1000, 1'b0, 1'b0, 1'b0);
        samp_chk(10,  "thr_lock", S_TRACK,  1000, 1'b0, 1'b1, 1'b0);
        samp_chk(11,  "thr_b1",   S_TRACK,  1000, 1'b0, 1'b1, 1'b0);
        samp_chk(-11, "thr_loss", S_SETTLE, 1000, 1'b1, 1'b0, 1'b0);
        stop_chk("stop2", 1000);

        // Range exhaustion with config changed after start (must be ignored)
        bus.f_stop = 1100;
        start_chk("start3", 1000);
        bus.f_stop   = 5000;
        bus.f_step   = 7;
        bus.lock_thr = 2047;
        for (int k = 0; k < 3; k++) begin
            repeat (7) sample(-300);
            samp_chk(-300, "fail_sweep", S_SWEEP, PW'(1000 + 50 * k), 1'b1, 1'b0, 1'b0);
            if (k < 2)
                idle_chk("fail_step", S_SETTLE, PW'(1050 + 50 * k), 1'b0, 1'b0, 1'b0);
            else
                idle_chk("fail_enter", S_FAIL, 1100, 1'b1, 1'b0, 1'b1);
        end
        idle_chk("fail_hold", S_FAIL, 1100, 1'b1, 1'b0, 1'b1);
        bus.f_stop   = 2000;
        bus.f_step   = 50;
        bus.lock_thr = 10;
        start_chk("restart", 1000);

        // stop beats start and err_vld in the same cycle
        bus.stop    = 1'b1;
        bus.start   = 1'b1;
        bus.err     = 5;
        bus.err_vld = 1'b1;
        expect_out("prio", S_IDLE, 1000, 1'b1, 1'b0, 1'b0);
        tick();
        bus.stop    = 1'b0;
        bus.start   = 1'b0;
        bus.err_vld = 1'b0;
        check_sb();
        samp_chk(5, "idle_ign", S_IDLE, 1000, 1'b1, 1'b0, 1'b0);

        // Reset mid-operation, then counters must start from zero
        start_chk("start4", 1000);
        samp_chk(5, "pre_rst", S_SETTLE, 1000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        expect_out("mid_rst", S_IDLE, 0, 1'b1, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        check_sb();
        start_chk("start5", 1000);
        samp_chk(5, "r_g1",   S_SETTLE, 1000, 1'b0, 1'b0, 1'b0);
        samp_chk(5, "r_g2",   S_SETTLE, 1000, 1'b0, 1'b0, 1'b0);
        samp_chk(5, "r_g3",   S_SETTLE, 1000, 1'b0, 1'b0, 1'b0);
        samp_chk(5, "r_lock", S_TRACK,  1000, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/adpll_acq_ctrl.md
Name: adpll_acq_ctrl

Overview:
- Acquisition and lock sequencer for the ADPLL loop.
- Drives the loop's base_freq and PI-filter reset.
- Watches the filtered phase-error stream (one sample per decimated strobe) and steps base_freq across a configured range until the error stays inside a threshold.
- Declares lock, tracks loss of lock and re-acquires automatically; declares failure if the range is exhausted.

Parameters:
PW, 32, width of frequency words (matches DDS phase-accumulator width)
EW, 12, width of signed phase-error sample
DWELL, 256, error samples evaluated per frequency step before stepping
LOCK_CNT, 64, consecutive in-threshold samples required to declare lock
UNLOCK_CNT, 16, consecutive out-of-threshold samples in TRACK to declare loss

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  begin acquisition; accepted in IDLE and FAIL only
stop  in  1  return to IDLE from any state
err_vld  in  1  phase-error sample strobe (decimated-rate enable)
err  in  EW  signed filtered phase error, valid when err_vld=1
f_start  in  PW  signed first base frequency
f_stop  in  PW  signed last allowed base frequency
f_step  in  PW  signed positive frequency increment
lock_thr  in  EW-1  unsigned magnitude threshold
base_freq  out  PW  signed frequency word to loop/DDS
pi_rst  out  1  holds the loop PI integrator in reset
locked  out  1  lock indication
sweep_fail  out  1  range exhausted without lock
state  out  3  IDLE=0, SETTLE=1, SWEEP=2, TRACK=3, FAIL=4

Behaviour:
- Reset values: state=IDLE, base_freq=0, pi_rst=1, locked=0, sweep_fail=0, all counters 0.
- Outputs are registered or decoded from the registered state only; no combinational path from inputs to outputs.
- pi_rst=1 in IDLE, SWEEP and FAIL; 0 in SETTLE and TRACK.
- locked=1 only in TRACK. sweep_fail=1 only in FAIL.
- Magnitude: |err| is computed at EW+1 bits, so err=-2^(EW-1) gives 2^(EW-1) without overflow. A sample is "good" when |err| <= lock_thr.
- Config latch: f_stop, f_step and lock_thr are latched on an accepted start; later input changes have no effect until the next start.
- IDLE: on start, in the next cycle state=SETTLE, base_freq=f_start, dwell_cnt=0, good_cnt=0.
- SETTLE, per err_vld:
  - dwell_cnt increments.
  - A good sample increments good_cnt; a bad sample clears good_cnt.
  - When good_cnt reaches LOCK_CNT, go to TRACK and clear bad_cnt.
  - Otherwise, when dwell_cnt reaches DWELL, go to SWEEP.
  - If lock and dwell expiry fall on the same sample, lock wins.
- SWEEP: lasts exactly one cycle.
  - Compute next = base_freq + f_step at PW+1 bits, signed.
  - If next > f_stop: go to FAIL, base_freq unchanged.
  - Else: base_freq=next, clear dwell_cnt and good_cnt, go to SETTLE.
  - err_vld during SWEEP is ignored.
- TRACK, per err_vld:
  - A bad sample increments bad_cnt; a good sample clears bad_cnt.
  - When bad_cnt reaches UNLOCK_CNT: go to SWEEP-free re-acquire, i.e. next cycle state=SETTLE, base_freq=f_start, counters cleared, locked=0.
  - pi_rst is asserted for exactly that transition cycle, then deasserted in SETTLE.
- FAIL: held until start (restart identical to IDLE start) or stop.
- stop: has priority over start, err_vld and all transitions. Next cycle state=IDLE; base_freq holds its value; counters cleared.
- start while in SETTLE, SWEEP or TRACK is ignored.
- Counters saturate logically: each reaching its terminal count forces the transition, so no wrap is possible.
- rst mid-operation returns all outputs to reset values in the next cycle.

Test Plan:
All scenarios use bench parameters DWELL=8, LOCK_CNT=4, UNLOCK_CNT=2, EW=12.
1. Reset: assert rst 2 cycles -> state=0, base_freq=0, pi_rst=1, locked=0, sweep_fail=0.
2. Immediate lock: start with f_start=1000, lock_thr=10, then 4 samples err=5 -> state=TRACK and locked=1 the cycle after the 4th err_vld; base_freq=1000; pi_rst=0.
3. Step: f_start=1000, f_step=50, f_stop=2000, 8 samples err=100 -> one SWEEP cycle with pi_rst=1, then SETTLE with base_freq=1050. A good-good-bad-good pattern keeps good_cnt below 4 with no lock.
4. Fail: f_stop=1100, all samples err=-300 -> base_freq visits 1000, 1050, 1100, then state=FAIL, sweep_fail=1, base_freq=1100. A new start returns base_freq to 1000.
5. Loss of lock: in TRACK, feed err=-2048, err=3, err=-2048 -> no loss (bad_cnt cleared by the good sample). Then err=-2048 twice -> locked=0, one cycle of pi_rst=1, state=SETTLE, base_freq=1000.
6. Priority: stop asserted in SETTLE in the same cycle as err_vld and start -> next cycle state=IDLE, pi_rst=1, base_freq unchanged.
